multdiv_unit: RTL and testbench



---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_signfix.sv | 12 +
 rtl/multdiv_unit.sv | 172 +++++++++++++++++
 tb/tb_multdiv_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    localparam int unsigned DIV0_MAX_W = 64;
    localparam logic [DIV0_MAX_W-1:0] DIV0_LO = '1;

endpackage

// File: rtl/multdiv_signfix.sv
// Conditional two's-complement negate: magnitude extraction and result sign fix-up.
module multdiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/multdiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, HI/LO registers.
// Optional MTHI/MTLO write ports are enabled with `define MULTDIV_HILO_WRITE_EN.
import multdiv_pkg::*;

module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandoA,
    input  logic [WIDTH-1:0] operandoB,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULTDIV_HILO_WRITE_EN
    ,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] entrada_hilo
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opr_q, opr_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 neg_q, neg_d, negrem_q, negrem_d;
    logic                 done_q, done_d, dz_q, dz_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     mag_a, mag_b, quot_fix, rem_fix;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic                 op_is_div;

    multdiv_signfix #(.W(WIDTH)) u_mag_a (
        .val_i(operandoA), .neg_i(~op[0] & operandoA[WIDTH-1]), .res_o(mag_a));
    multdiv_signfix #(.W(WIDTH)) u_mag_b (
        .val_i(operandoB), .neg_i(~op[0] & operandoB[WIDTH-1]), .res_o(mag_b));
    multdiv_signfix #(.W(2*WIDTH)) u_fix_prod (
        .val_i(acc_q), .neg_i(neg_q), .res_o(prod_fix));
    multdiv_signfix #(.W(WIDTH)) u_fix_quot (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_q), .res_o(quot_fix));
    multdiv_signfix #(.W(WIDTH)) u_fix_rem (
        .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(negrem_q), .res_o(rem_fix));

    assign op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Upper half of acc is the running product / partial remainder; lower half
    // holds the multiplier or dividend bits still to be consumed.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opr_q} : '0);
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opr_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opr_d    = opr_q;
        a_raw_d  = a_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        negrem_d = negrem_q;
        dz_d     = dz_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    op_d     = op_e'(op);
                    a_raw_d  = operandoA;
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    neg_d    = ~op[0] & (operandoA[WIDTH-1] ^ operandoB[WIDTH-1]);
                    negrem_d = ~op[0] & op[1] & operandoA[WIDTH-1];
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                        opr_d = mag_b;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                        opr_d = mag_a;
                    end
                end
`ifdef MULTDIV_HILO_WRITE_EN
                else begin
                    if (wr_hi) hi_d = entrada_hilo;
                    if (wr_lo) lo_d = entrada_hilo;
                end
`endif
            end
            S_RUN: begin
                if (op_is_div) begin
                    // div_diff sign bit is the borrow: set means restore.
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1))
                    state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_is_div) begin
                    if (opr_q == '0) begin
                        lo_d = DIV0_LO[WIDTH-1:0];
                        hi_d = a_raw_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULT;
            acc_q    <= '0;
            opr_q    <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            negrem_q <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opr_q    <= opr_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            negrem_q <= negrem_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: vector table plus hand-written multi-cycle sequences.
module tb_multdiv_unit;

    localparam int unsigned W = 32;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [1:0]    op;
    logic [W-1:0]  operandoA, operandoB;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;
`ifdef MULTDIV_HILO_WRITE_EN
    logic          wr_hi, wr_lo;
    logic [W-1:0]  entrada_hilo;
`endif

    multdiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operandoA(operandoA), .operandoB(operandoB),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
`ifdef MULTDIV_HILO_WRITE_EN
        , .wr_hi(wr_hi), .wr_lo(wr_lo), .entrada_hilo(entrada_hilo)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op, checks timing, returns hi/lo/div_by_zero sampled in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] hi_s,
                          output logic [W-1:0] lo_s, output logic dz_s);
        int lat;
        int busy_n;
        op = o; operandoA = a; operandoB = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0; busy_n = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clock); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " busy cycles"}, 64'(busy_n), 64'd32);
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        hi_s = hi; lo_s = lo; dz_s = div_by_zero;
        @(posedge clock); #1;
        check({tag, " done pulse width"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] h, l;
        logic         z;
        int           lat, extra;

        vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'd3, 32'd250,      32'd25,       32'h00000000, 32'd10,       1'b0};
        vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[6]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{2'd0, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
        vecs[8]  = '{2'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{2'd3, 32'd275,      32'd0,        32'd275,      32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};

        reset = 1'b0; start = 1'b0; op = '0; operandoA = '0; operandoB = '0;
`ifdef MULTDIV_HILO_WRITE_EN
        wr_hi = 1'b0; wr_lo = 1'b0; entrada_hilo = '0;
`endif
        #2;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dz",   64'(div_by_zero), 64'd0);
        check("reset hi",   64'(hi), 64'd0);
        check("reset lo",   64'(lo), 64'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, h, l, z);
            check($sformatf("vec%0d hi", i), 64'(h), 64'(vecs[i].hi));
            check($sformatf("vec%0d lo", i), 64'(l), 64'(vecs[i].lo));
            check($sformatf("vec%0d dz", i), 64'(z), 64'(vecs[i].dz));
        end

        // div_by_zero and HI/LO hold while idle
        repeat (5) @(posedge clock);
        #1;
        check("dz sticky", 64'(div_by_zero), 64'd1);
        check("hi hold",   64'(hi), 64'hFFFFFFFB);
        check("lo hold",   64'(lo), 64'hFFFFFFFF);

        // MULT 6x7 with an ignored second start and operand changes mid-run
        op = 2'd0; operandoA = 32'd6; operandoB = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("dz cleared by start", 64'(div_by_zero), 64'd0);
        check("busy after start",    64'(busy), 64'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 4) begin
                start = 1'b1; op = 2'd3; operandoA = 32'd100; operandoB = 32'd100;
            end else if (lat == 5) begin
                start = 1'b0; operandoA = 32'hDEAD; operandoB = 32'hBEEF;
            end
            @(posedge clock); #1;
            lat++;
        end
        check("ignored-start latency", 64'(lat), 64'd33);
        check("ignored-start hi", 64'(hi), 64'd0);
        check("ignored-start lo", 64'(lo), 64'd42);
        extra = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done === 1'b1) extra++;
        end
        check("no second done", 64'(extra), 64'd0);
        check("idle after single op", 64'(busy), 64'd0);

        // asynchronous reset in the middle of a divide
        op = 2'd2; operandoA = 32'd100; operandoB = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("busy before reset", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset dz",   64'(div_by_zero), 64'd0);
        check("mid reset hi",   64'(hi), 64'd0);
        check("mid reset lo",   64'(lo), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run_op("post-reset", 2'd1, 32'd2, 32'd3, h, l, z);
        check("post-reset hi", 64'(h), 64'd0);
        check("post-reset lo", 64'(l), 64'd6);

`ifdef MULTDIV_HILO_WRITE_EN
        wr_lo = 1'b1; entrada_hilo = 32'h1234;
        @(posedge clock); #1;
        wr_lo = 1'b0;
        check("wr_lo idle", 64'(lo), 64'h1234);
        check("wr_lo leaves hi", 64'(hi), 64'd0);

        wr_lo = 1'b1; entrada_hilo = 32'h5555;
        op = 2'd1; operandoA = 32'd3; operandoB = 32'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; wr_lo = 1'b0;
        check("wr_lo with start dropped", 64'(lo), 64'h1234);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        check("wr-start op lo", 64'(lo), 64'd9);

        wr_hi = 1'b1; wr_lo = 1'b1; entrada_hilo = 32'hABCD;
        @(posedge clock); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr both hi", 64'(hi), 64'hABCD);
        check("wr both lo", 64'(lo), 64'hABCD);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
